// File: rtl/pixel_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_arb_pkg
// Desc     : Shared widths and types for the PixelOCM round-robin arbiter.
// Revision : 1.0
// ============================================================================
package pixel_arb_pkg;

    localparam int PIX_ADDR_W = 10;
    localparam int PIX_DATA_W = 32;
    localparam int PIX_BE_W   = 4;
    localparam int REQ_ID_W   = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                valid;
        logic [REQ_ID_W-1:0] id;
    } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/pixel_ocm_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : pixel_ocm_arbiter_if
// Desc     : Requester-side and PixelOCM-side Avalon-MM bundle of the arbiter.
// Revision : 1.0
// ============================================================================
interface pixel_ocm_arbiter_if
    import pixel_arb_pkg::*;
#(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]            m_read;
    logic [N_REQ-1:0]            m_write;
    logic [N_REQ*PIX_ADDR_W-1:0] m_address;
    logic [N_REQ*PIX_BE_W-1:0]   m_byteenable;
    logic [N_REQ*PIX_DATA_W-1:0] m_writedata;
    logic [N_REQ-1:0]            m_waitrequest;
    logic [PIX_DATA_W-1:0]       m_readdata;
    logic [N_REQ-1:0]            m_readdatavalid;

    logic                        AVL_READ;
    logic                        AVL_WRITE;
    logic                        AVL_CS;
    logic [PIX_ADDR_W-1:0]       AVL_ADDRESS;
    logic [PIX_BE_W-1:0]         AVL_BYTE_EN;
    logic [PIX_DATA_W-1:0]       AVL_WRITEDATA;
    logic [PIX_DATA_W-1:0]       AVL_READDATA;
    logic                        AVL_WAIT_REQUEST;

    // Arbiter view: slave to the requesters, master to the PixelOCM.
    modport slave (
        input  m_read, m_write, m_address, m_byteenable, m_writedata,
        output m_waitrequest, m_readdata, m_readdatavalid,
        output AVL_READ, AVL_WRITE, AVL_CS, AVL_ADDRESS, AVL_BYTE_EN, AVL_WRITEDATA,
        input  AVL_READDATA, AVL_WAIT_REQUEST
    );

    modport master (
        output m_read, m_write, m_address, m_byteenable, m_writedata,
        input  m_waitrequest, m_readdata, m_readdatavalid,
        input  AVL_READ, AVL_WRITE, AVL_CS, AVL_ADDRESS, AVL_BYTE_EN, AVL_WRITEDATA,
        output AVL_READDATA, AVL_WAIT_REQUEST
    );

endinterface
`default_nettype wire

// File: rtl/pixel_arb_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : pixel_arb_rr_picker
// Desc     : Combinational round-robin search upward from ptr with wrap-around.
// Revision : 1.0
// ============================================================================
module pixel_arb_rr_picker
    import pixel_arb_pkg::*;
#(
    parameter int N_REQ = 3
)(
    input  logic [N_REQ-1:0]    req,
    input  logic [REQ_ID_W-1:0] ptr,
    output logic [REQ_ID_W-1:0] winner,
    output logic                any
);

    logic [N_REQ-1:0] rot;

    // Rotate so that bit 0 is the requester at ptr; ptr is always < N_REQ.
    assign rot = N_REQ'({req, req} >> ptr);

    always_comb begin
        int pos;
        winner = '0;
        any    = 1'b0;
        pos    = 0;
        // Descending scan: the lowest rotated index is written last and wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pos = int'(ptr) + k;
                if (pos >= N_REQ) begin
                    pos = pos - N_REQ;
                end
                winner = REQ_ID_W'(pos);
                any    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pixel_ocm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pixel_ocm_arbiter
// Desc     : Round-robin, hold-bounded arbiter in front of the PixelOCM with
//            tagged read-data routing. Optional macro: PIXEL_ARB_PERF_EN.
// Revision : 1.0
// ============================================================================
module pixel_ocm_arbiter
    import pixel_arb_pkg::*;
#(
    parameter int N_REQ    = 3,
    parameter int MAX_HOLD = 4,
    parameter int RD_LAT   = 1
)(
    input  logic                 Clk,
    input  logic                 Reset_n,
    pixel_ocm_arbiter_if.slave   bus,
    output logic [REQ_ID_W-1:0]  grant_id,
    output logic                 busy
`ifdef PIXEL_ARB_PERF_EN
   ,input  logic                 perf_clr,
    output logic [N_REQ*16-1:0]  wait_cnt
`endif
);

    localparam int HOLD_W = 4;

    arb_state_t            state, state_nxt;
    logic [REQ_ID_W-1:0]   rr_ptr, ptr_nxt, grant_nxt, winner;
    logic [HOLD_W-1:0]     hold_cnt, hold_nxt;
    logic [N_REQ-1:0]      req_vec;
    logic                  any_req;
    logic                  own_rd, own_wr, own_req, accept, rd_accept, release_grant;
    logic [PIX_ADDR_W-1:0] own_addr;
    logic [PIX_BE_W-1:0]   own_be;
    logic [PIX_DATA_W-1:0] own_wdata;
    rd_tag_t               tag_pipe [RD_LAT];

    assign req_vec = bus.m_read | bus.m_write;

    pixel_arb_rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req    (req_vec),
        .ptr    (rr_ptr),
        .winner (winner),
        .any    (any_req)
    );

    always_comb begin
        own_rd    = 1'b0;
        own_wr    = 1'b0;
        own_addr  = '0;
        own_be    = '0;
        own_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == REQ_ID_W'(i)) begin
                own_rd    = bus.m_read[i];
                own_wr    = bus.m_write[i];
                own_addr  = bus.m_address[i*PIX_ADDR_W +: PIX_ADDR_W];
                own_be    = bus.m_byteenable[i*PIX_BE_W +: PIX_BE_W];
                own_wdata = bus.m_writedata[i*PIX_DATA_W +: PIX_DATA_W];
            end
        end
    end

    assign own_req           = own_rd | own_wr;
    assign bus.AVL_ADDRESS   = own_addr;
    assign bus.AVL_BYTE_EN   = own_be;
    assign bus.AVL_WRITEDATA = own_wdata;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            grant_id <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= ptr_nxt;
            hold_cnt <= hold_nxt;
            grant_id <= grant_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        ptr_nxt           = rr_ptr;
        hold_nxt          = hold_cnt;
        grant_nxt         = grant_id;
        accept            = 1'b0;
        rd_accept         = 1'b0;
        release_grant     = 1'b0;
        bus.AVL_READ      = 1'b0;
        bus.AVL_WRITE     = 1'b0;
        bus.AVL_CS        = 1'b0;
        bus.m_waitrequest = '1;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_nxt = winner;
                    hold_nxt  = '0;
                    state_nxt = OWN;
                end
            end
            OWN: begin
                // Write has priority when the owner raises both strobes.
                bus.AVL_WRITE = own_wr;
                bus.AVL_READ  = own_rd & ~own_wr;
                bus.AVL_CS    = own_req;
                for (int i = 0; i < N_REQ; i++) begin
                    if (grant_id == REQ_ID_W'(i)) begin
                        bus.m_waitrequest[i] = bus.AVL_WAIT_REQUEST;
                    end
                end
                accept        = own_req & ~bus.AVL_WAIT_REQUEST;
                rd_accept     = accept & ~own_wr;
                release_grant = ~own_req | (accept & (hold_cnt == HOLD_W'(MAX_HOLD - 1)));
                if (accept) begin
                    hold_nxt = hold_cnt + 4'd1;
                end
                if (release_grant) begin
                    hold_nxt  = '0;
                    state_nxt = IDLE;
                    ptr_nxt   = (grant_id == REQ_ID_W'(N_REQ - 1)) ? '0 : grant_id + 3'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Tags follow the PixelOCM read latency; reset discards anything in flight.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int k = 0; k < RD_LAT; k++) begin
                tag_pipe[k] <= '0;
            end
        end else begin
            tag_pipe[0] <= {rd_accept, grant_id};
            for (int k = 1; k < RD_LAT; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            bus.m_readdatavalid[i] = tag_pipe[RD_LAT-1].valid &&
                                     (tag_pipe[RD_LAT-1].id == REQ_ID_W'(i));
        end
    end

    assign bus.m_readdata = bus.AVL_READDATA;
    assign busy           = (state == OWN);

`ifdef PIXEL_ARB_PERF_EN
    logic [15:0] wait_cnt_q [N_REQ];

    always_ff @(posedge Clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (!Reset_n || perf_clr) begin
                wait_cnt_q[i] <= '0;
            end else if (req_vec[i] && bus.m_waitrequest[i] && (wait_cnt_q[i] != 16'hFFFF)) begin
                wait_cnt_q[i] <= wait_cnt_q[i] + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_wait_cnt
        assign wait_cnt[g*16 +: 16] = wait_cnt_q[g];
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_ocm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_ocm_arbiter
// Desc     : Directed scenarios plus randomized traffic against a reference model.
// Revision : 1.0
// ============================================================================
module tb_pixel_ocm_arbiter;
    import pixel_arb_pkg::*;

    localparam int N_REQ    = 3;
    localparam int MAX_HOLD = 4;
    localparam int RD_LAT   = 1;

    logic                Clk = 1'b0;
    logic                Reset_n = 1'b0;
    logic [REQ_ID_W-1:0] grant_id;
    logic                busy;
    int                  checks = 0;
    int                  passed = 0;
`ifdef PIXEL_ARB_PERF_EN
    logic                perf_clr = 1'b0;
    logic [N_REQ*16-1:0] wait_cnt;
`endif

    pixel_ocm_arbiter_if #(.N_REQ(N_REQ)) bus ();

    pixel_ocm_arbiter #(.N_REQ(N_REQ), .MAX_HOLD(MAX_HOLD), .RD_LAT(RD_LAT)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy)
`ifdef PIXEL_ARB_PERF_EN
       ,.perf_clr (perf_clr),
        .wait_cnt (wait_cnt)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic clear_inputs();
        bus.m_read           = '0;
        bus.m_write          = '0;
        bus.m_address        = '0;
        bus.m_byteenable     = '0;
        bus.m_writedata      = '0;
        bus.AVL_READDATA     = '0;
        bus.AVL_WAIT_REQUEST = 1'b0;
    endtask

    // Leaves the bench at posedge+1 of the first cycle with reset released.
    task automatic do_reset();
        Reset_n = 1'b0;
        clear_inputs();
        cyc();
        cyc();
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        mid();
        checks++; if (bus.m_waitrequest !== 3'b111) $display("FAIL reset_waitreq got=%b exp=111", bus.m_waitrequest); else passed++;
        checks++; if (bus.m_readdatavalid !== 3'b000) $display("FAIL reset_rdvalid got=%b exp=000", bus.m_readdatavalid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        checks++; if (grant_id !== 3'd0) $display("FAIL reset_grant got=%0d exp=0", grant_id); else passed++;
        checks++; if ({bus.AVL_CS, bus.AVL_READ, bus.AVL_WRITE} !== 3'b000) $display("FAIL reset_avl got=%b exp=000", {bus.AVL_CS, bus.AVL_READ, bus.AVL_WRITE}); else passed++;
        cyc();
    endtask

    task automatic test_single_write();
        do_reset();
        bus.m_write[1]           = 1'b1;
        bus.m_address[10 +: 10]  = 10'h005;
        bus.m_byteenable[4 +: 4] = 4'b0010;
        bus.m_writedata[32 +: 32] = 32'h0000_0300;
        mid();
        checks++; if ({busy, bus.AVL_WRITE, bus.m_waitrequest} !== 5'b00111) $display("FAIL wr_arb_cycle got=%b exp=00111", {busy, bus.AVL_WRITE, bus.m_waitrequest}); else passed++;
        cyc(); mid();
        checks++; if ({busy, grant_id} !== {1'b1, 3'd1}) $display("FAIL wr_grant got=%b/%0d exp=1/1", busy, grant_id); else passed++;
        checks++; if ({bus.AVL_CS, bus.AVL_READ, bus.AVL_WRITE} !== 3'b101) $display("FAIL wr_strobes got=%b exp=101", {bus.AVL_CS, bus.AVL_READ, bus.AVL_WRITE}); else passed++;
        checks++; if ({bus.AVL_ADDRESS, bus.AVL_BYTE_EN, bus.AVL_WRITEDATA} !== {10'h005, 4'b0010, 32'h0000_0300}) $display("FAIL wr_fields got=%h/%b/%h exp=005/0010/00000300", bus.AVL_ADDRESS, bus.AVL_BYTE_EN, bus.AVL_WRITEDATA); else passed++;
        checks++; if (bus.m_waitrequest !== 3'b101) $display("FAIL wr_waitreq got=%b exp=101", bus.m_waitrequest); else passed++;
        cyc();
        bus.m_write[1] = 1'b0;
        mid();
        checks++; if (bus.AVL_CS !== 1'b0) $display("FAIL wr_cs_drop got=%b exp=0", bus.AVL_CS); else passed++;
        cyc(); mid();
        checks++; if (busy !== 1'b0) $display("FAIL wr_release got=%b exp=0", busy); else passed++;
        cyc();
    endtask

    task automatic test_round_robin();
        int run, run_max, last;
        do_reset();
        bus.m_write[0] = 1'b1;
        bus.m_write[2] = 1'b1;
        run = 0; run_max = 0; last = -1;
        for (int c = 0; c < 20; c++) begin
            int obs, exp_id;
            mid();
            obs = -1;
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.m_write[i] && !bus.m_waitrequest[i]) obs = i;
            end
            // Period of MAX_HOLD+1: one arbitration bubble, then a full burst.
            exp_id = ((c % 5) == 0) ? -1 : (((c / 5) % 2 == 0) ? 0 : 2);
            checks++; if (obs !== exp_id) $display("FAIL rr_owner c=%0d got=%0d exp=%0d", c, obs, exp_id); else passed++;
            run = (obs >= 0 && obs == last) ? run + 1 : ((obs >= 0) ? 1 : 0);
            last = obs;
            if (run > run_max) run_max = run;
            cyc();
        end
        checks++; if (run_max > MAX_HOLD) $display("FAIL rr_max_hold got=%0d exp<=%0d", run_max, MAX_HOLD); else passed++;
        clear_inputs();
        cyc(); cyc();
    endtask

    task automatic test_read_route();
        do_reset();
        bus.AVL_READDATA        = 32'hDEAD_BEEF;
        bus.m_read[1]           = 1'b1;
        bus.m_address[10 +: 10] = 10'h020;
        mid(); cyc();
        bus.m_write[0] = 1'b1;
        mid();
        checks++; if ({bus.AVL_READ, bus.AVL_ADDRESS} !== {1'b1, 10'h020}) $display("FAIL rd_issue got=%b/%h exp=1/020", bus.AVL_READ, bus.AVL_ADDRESS); else passed++;
        checks++; if (bus.m_waitrequest !== 3'b101) $display("FAIL rd_waitreq got=%b exp=101", bus.m_waitrequest); else passed++;
        checks++; if (bus.m_readdatavalid !== 3'b000) $display("FAIL rd_early_valid got=%b exp=000", bus.m_readdatavalid); else passed++;
        cyc();
        bus.m_read[1] = 1'b0;
        mid();
        checks++; if (bus.m_readdatavalid !== 3'b010) $display("FAIL rd_valid got=%b exp=010", bus.m_readdatavalid); else passed++;
        checks++; if (bus.m_readdata !== 32'hDEAD_BEEF) $display("FAIL rd_data got=%h exp=deadbeef", bus.m_readdata); else passed++;
        cyc(); mid();
        checks++; if (bus.m_readdatavalid !== 3'b000) $display("FAIL rd_valid_once got=%b exp=000", bus.m_readdatavalid); else passed++;
        clear_inputs();
        cyc(); cyc(); cyc();
    endtask

    task automatic test_stall();
        int acc, rdv;
        do_reset();
        bus.m_read[0]        = 1'b1;
        bus.AVL_WAIT_REQUEST = 1'b1;
        mid();
        for (int c = 1; c <= 3; c++) begin
            cyc(); mid();
            checks++; if ({busy, grant_id, bus.AVL_READ, bus.m_waitrequest[0]} !== {1'b1, 3'd0, 1'b1, 1'b1}) $display("FAIL stall_hold c=%0d got=%b exp=100011", c, {busy, grant_id, bus.AVL_READ, bus.m_waitrequest[0]}); else passed++;
        end
        acc = 0; rdv = 0;
        for (int c = 4; c <= 9; c++) begin
            cyc();
            bus.AVL_WAIT_REQUEST = 1'b0;
            if (c == 8) bus.m_read[0] = 1'b0;
            mid();
            if (bus.AVL_READ && !bus.m_waitrequest[0]) acc++;
            if (bus.m_readdatavalid[0]) rdv++;
            if (c == 8) begin
                checks++; if (busy !== 1'b0) $display("FAIL stall_release got=%b exp=0", busy); else passed++;
            end
        end
        checks++; if (acc !== MAX_HOLD) $display("FAIL stall_accepts got=%0d exp=%0d", acc, MAX_HOLD); else passed++;
        checks++; if (rdv !== MAX_HOLD) $display("FAIL stall_rdvalid got=%0d exp=%0d", rdv, MAX_HOLD); else passed++;
        cyc();
    endtask

    task automatic test_reset_inflight();
        int rdv;
        do_reset();
        bus.m_write[0] = 1'b1;
        cyc();
        cyc();
        bus.m_write[0] = 1'b0;
        cyc();
        bus.m_read[1] = 1'b1;
        cyc();
        Reset_n = 1'b0;
        cyc();
        Reset_n = 1'b1;
        bus.m_read[1] = 1'b0;
        mid();
        checks++; if (bus.m_waitrequest !== 3'b111) $display("FAIL rst_waitreq got=%b exp=111", bus.m_waitrequest); else passed++;
        rdv = 0;
        for (int c = 0; c < 3; c++) begin
            if (bus.m_readdatavalid !== 3'b000) rdv++;
            cyc(); mid();
        end
        checks++; if (rdv !== 0) $display("FAIL rst_dropped_valid got=%0d exp=0", rdv); else passed++;
        cyc();
        bus.m_write = 3'b111;
        cyc(); mid();
        checks++; if ({busy, grant_id} !== {1'b1, 3'd0}) $display("FAIL rst_first_winner got=%b/%0d exp=1/0", busy, grant_id); else passed++;
        clear_inputs();
        cyc(); cyc();
    endtask

`ifdef PIXEL_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        bus.m_read[2]        = 1'b1;
        bus.AVL_WAIT_REQUEST = 1'b1;
        for (int c = 0; c < 20; c++) cyc();
        bus.m_read[2] = 1'b0;
        mid();
        checks++; if (wait_cnt[32 +: 16] !== 16'd20) $display("FAIL perf_count got=%0d exp=20", wait_cnt[32 +: 16]); else passed++;
        cyc();
        perf_clr = 1'b1;
        cyc();
        perf_clr = 1'b0;
        mid();
        checks++; if (wait_cnt[32 +: 16] !== 16'd0) $display("FAIL perf_clear got=%0d exp=0", wait_cnt[32 +: 16]); else passed++;
        clear_inputs();
        cyc(); cyc();
    endtask
`endif

    // Reference: who owns the bus, how many transfers it has had, where the
    // next search starts, and a queue of read owners due back from the OCM.
    task automatic test_random();
        bit owned;
        int owner, ptr, used;
        int rdq[$];
        do_reset();
        owned = 0; owner = 0; ptr = 0; used = 0;
        rdq.delete();
        for (int k = 0; k < RD_LAT; k++) rdq.push_back(-1);
        for (int c = 0; c < 400; c++) begin
            logic [N_REQ-1:0] exp_wait, exp_rdv, reqs;
            logic             exp_wr, exp_rd, acc;
            for (int i = 0; i < N_REQ; i++) begin
                int r;
                r = $urandom_range(0, 5);
                bus.m_read[i]  = (r == 3 || r == 5);
                bus.m_write[i] = (r == 4 || r == 5);
            end
            bus.m_address        = N_REQ*PIX_ADDR_W'($urandom);
            bus.m_byteenable     = N_REQ*PIX_BE_W'($urandom);
            bus.m_writedata      = {$urandom, $urandom, $urandom};
            bus.AVL_READDATA     = $urandom;
            bus.AVL_WAIT_REQUEST = ($urandom_range(0, 3) == 0);
            mid();
            reqs     = bus.m_read | bus.m_write;
            exp_wr   = owned && bus.m_write[owner];
            exp_rd   = owned && bus.m_read[owner] && !exp_wr;
            exp_wait = '1;
            if (owned) exp_wait[owner] = bus.AVL_WAIT_REQUEST;
            exp_rdv  = (rdq[0] >= 0) ? N_REQ'(1 << rdq[0]) : '0;
            checks++; if (bus.m_waitrequest !== exp_wait) $display("FAIL rnd_waitreq c=%0d got=%b exp=%b", c, bus.m_waitrequest, exp_wait); else passed++;
            checks++; if ({bus.AVL_CS, bus.AVL_READ, bus.AVL_WRITE} !== {exp_rd | exp_wr, exp_rd, exp_wr}) $display("FAIL rnd_strobes c=%0d got=%b exp=%b", c, {bus.AVL_CS, bus.AVL_READ, bus.AVL_WRITE}, {exp_rd | exp_wr, exp_rd, exp_wr}); else passed++;
            checks++; if (bus.m_readdatavalid !== exp_rdv) $display("FAIL rnd_rdvalid c=%0d got=%b exp=%b", c, bus.m_readdatavalid, exp_rdv); else passed++;
            checks++; if (busy !== owned) $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, owned); else passed++;
            if (owned) begin
                checks++; if (grant_id !== REQ_ID_W'(owner)) $display("FAIL rnd_grant c=%0d got=%0d exp=%0d", c, grant_id, owner); else passed++;
            end
            if (exp_rd || exp_wr) begin
                checks++; if (bus.AVL_ADDRESS !== bus.m_address[owner*PIX_ADDR_W +: PIX_ADDR_W]) $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, bus.AVL_ADDRESS, bus.m_address[owner*PIX_ADDR_W +: PIX_ADDR_W]); else passed++;
            end
            acc = (exp_rd || exp_wr) && !bus.AVL_WAIT_REQUEST;
            void'(rdq.pop_front());
            rdq.push_back((acc && exp_rd) ? owner : -1);
            if (!owned) begin
                for (int k = N_REQ - 1; k >= 0; k--) begin
                    if (reqs[(ptr + k) % N_REQ]) begin
                        owner = (ptr + k) % N_REQ;
                        owned = 1;
                    end
                end
                used = 0;
            end else begin
                if (acc) used++;
                if (!(exp_rd || exp_wr) || (acc && used == MAX_HOLD)) begin
                    owned = 0;
                    ptr   = (owner + 1) % N_REQ;
                end
            end
            cyc();
        end
        clear_inputs();
        cyc(); cyc();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_write();
        test_round_robin();
        test_read_route();
        test_stall();
        test_reset_inflight();
`ifdef PIXEL_ARB_PERF_EN
        test_perf();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
